// File: rtl/awb_pkg.sv
// Shared types and constants for the gray-world auto white balance statistics block.
package awb_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StAcc,
      StDivR,
      StDivB,
      StDone
   } awb_state_e;

   typedef enum logic [1:0] {
      CfaGrbg = 2'b00,
      CfaRggb = 2'b01,
      CfaBggr = 2'b10,
      CfaGbrg = 2'b11
   } cfa_e;

   function automatic logic [31:0] unity_gain(input int unsigned dec);
      return 32'd1 << dec;
   endfunction

endpackage

// File: rtl/awb_div.sv
// Sequential restoring divider: one check/load cycle, then one quotient bit per cycle.
module awb_div
   import awb_pkg::*;
#(
   parameter int unsigned NumW = 40,
   parameter int unsigned DenW = 32,
   parameter int unsigned QW   = 10,
   parameter int unsigned Dec  = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [NumW-1:0] numerator,
   input  logic [DenW-1:0] divisor,
   output logic            running,
   output logic            done,
   output logic [QW-1:0]   quotient
);

   localparam int unsigned WW = ((NumW > DenW + QW) ? NumW : DenW + QW) + 1;
   localparam int unsigned CW = $clog2(QW);

   logic [WW-1:0] rem_q, den_q;
   logic [WW-1:0] num_ext, den_ext;
   logic [CW-1:0] cnt_q;
   logic          fixed_q;

   assign num_ext = WW'(numerator);
   assign den_ext = WW'(divisor);
   assign done    = running && (cnt_q == '0);

   // Zero/saturated results are decided at load, then the bit loop still runs
   // so every division has the same latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         running  <= 1'b0;
         cnt_q    <= '0;
         fixed_q  <= 1'b0;
         rem_q    <= '0;
         den_q    <= '0;
         quotient <= '0;
      end else if (start) begin
         running  <= 1'b1;
         cnt_q    <= CW'(QW - 1);
         rem_q    <= num_ext;
         den_q    <= den_ext << (QW - 1);
         quotient <= '0;
         fixed_q  <= 1'b0;
         if (divisor == '0) begin
            quotient <= QW'(unity_gain(Dec));
            fixed_q  <= 1'b1;
         end else if (num_ext >= (den_ext << QW)) begin
            quotient <= '1;
            fixed_q  <= 1'b1;
         end
      end else if (running) begin
         if (!fixed_q) begin
            if (rem_q >= den_q) begin
               rem_q    <= rem_q - den_q;
               quotient <= {quotient[QW-2:0], 1'b1};
            end else begin
               quotient <= {quotient[QW-2:0], 1'b0};
            end
            den_q <= den_q >> 1;
         end
         if (cnt_q == '0) running <= 1'b0;
         else             cnt_q   <= cnt_q - 1'b1;
      end
   end

endmodule

// File: rtl/awb_gain_stat.sv
// Gray-world AWB: accumulates R/G/B over one Bayer frame, then derives R and B gains
// relative to the green average for use from the next frame.
module awb_gain_stat
   import awb_pkg::*;
#(
   parameter int unsigned DW_IN   = 10,
   parameter int unsigned DW_GAIN = 10,
   parameter int unsigned DW_DEC  = 8,
   parameter int unsigned DW_SUM  = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [1:0]           CFA,
   input  logic                 stat_en,
   input  logic                 vsync_in,
   input  logic                 hsync_in,
   input  logic [DW_IN*4-1:0]   data_in,
   output logic [DW_GAIN-1:0]   R_gain,
   output logic [DW_GAIN-1:0]   G_gain,
   output logic [DW_GAIN-1:0]   B_gain,
   output logic                 gain_valid,
   output logic                 busy
);

   localparam int unsigned NUM_W = DW_SUM + DW_DEC;
   localparam logic [DW_GAIN-1:0] UNITY = DW_GAIN'(unity_gain(DW_DEC));

   awb_state_e          state_q;
   logic                vs_q;
   logic [DW_SUM-1:0]   r_sum_q, g_sum_q, b_sum_q;
   logic [DW_GAIN-1:0]  r_res_q;

   logic [DW_IN-1:0]    p11, p12, p21, p22;
   logic [DW_IN-1:0]    r_pix, b_pix;
   logic [DW_IN:0]      g_pix;
   logic                quad_en, vs_rise, vs_fall;

   logic                div_start, div_running, div_done;
   logic [NUM_W-1:0]    div_num;
   logic [DW_SUM-1:0]   div_den;
   logic [DW_GAIN-1:0]  div_q;

   assign p11 = data_in[4*DW_IN-1 -: DW_IN];
   assign p12 = data_in[3*DW_IN-1 -: DW_IN];
   assign p21 = data_in[2*DW_IN-1 -: DW_IN];
   assign p22 = data_in[DW_IN-1 -: DW_IN];

   always_comb begin
      r_pix = '0;
      b_pix = '0;
      g_pix = '0;
      unique case (cfa_e'(CFA))
         CfaGrbg: begin r_pix = p12; b_pix = p21; g_pix = {1'b0, p11} + {1'b0, p22}; end
         CfaRggb: begin r_pix = p11; b_pix = p22; g_pix = {1'b0, p12} + {1'b0, p21}; end
         CfaBggr: begin r_pix = p22; b_pix = p11; g_pix = {1'b0, p12} + {1'b0, p21}; end
         CfaGbrg: begin r_pix = p21; b_pix = p12; g_pix = {1'b0, p11} + {1'b0, p22}; end
         default: ;
      endcase
   end

   function automatic logic [DW_SUM-1:0] sat_add(input logic [DW_SUM-1:0] a,
                                                 input logic [DW_SUM-1:0] b);
      logic [DW_SUM:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[DW_SUM] ? '1 : s[DW_SUM-1:0];
   endfunction

   assign quad_en = vsync_in & hsync_in;
   assign vs_rise = vsync_in & ~vs_q;
   assign vs_fall = ~vsync_in & vs_q;

   assign div_num   = NUM_W'(g_sum_q >> 1) << DW_DEC;
   assign div_den   = (state_q == StDivR) ? r_sum_q : b_sum_q;
   assign div_start = ((state_q == StDivR) || (state_q == StDivB)) && !div_running;

   awb_div #(
      .NumW (NUM_W),
      .DenW (DW_SUM),
      .QW   (DW_GAIN),
      .Dec  (DW_DEC)
   ) u_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (div_start),
      .numerator (div_num),
      .divisor   (div_den),
      .running   (div_running),
      .done      (div_done),
      .quotient  (div_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         vs_q       <= 1'b0;
         r_sum_q    <= '0;
         g_sum_q    <= '0;
         b_sum_q    <= '0;
         r_res_q    <= '0;
         R_gain     <= UNITY;
         G_gain     <= UNITY;
         B_gain     <= UNITY;
         gain_valid <= 1'b0;
         busy       <= 1'b0;
      end else begin
         vs_q       <= vsync_in;
         gain_valid <= 1'b0;
         case (state_q)
            StIdle: begin
               // The quad presented alongside the vsync rise belongs to the frame.
               if (vs_rise && stat_en) begin
                  state_q <= StAcc;
                  r_sum_q <= quad_en ? DW_SUM'(r_pix) : '0;
                  g_sum_q <= quad_en ? DW_SUM'(g_pix) : '0;
                  b_sum_q <= quad_en ? DW_SUM'(b_pix) : '0;
               end
            end
            StAcc: begin
               if (!stat_en) begin
                  state_q <= StIdle;
               end else if (vs_fall) begin
                  state_q <= StDivR;
                  busy    <= 1'b1;
               end else if (quad_en) begin
                  r_sum_q <= sat_add(r_sum_q, DW_SUM'(r_pix));
                  g_sum_q <= sat_add(g_sum_q, DW_SUM'(g_pix));
                  b_sum_q <= sat_add(b_sum_q, DW_SUM'(b_pix));
               end
            end
            StDivR: begin
               if (div_done) state_q <= StDivB;
            end
            StDivB: begin
               // Divider still holds the R quotient until the B load takes effect.
               if (div_start) r_res_q <= div_q;
               if (div_done) begin
                  state_q <= StDone;
                  busy    <= 1'b0;
               end
            end
            StDone: begin
               R_gain     <= r_res_q;
               G_gain     <= UNITY;
               B_gain     <= div_q;
               gain_valid <= 1'b1;
               state_q    <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_awb_gain_stat.sv
// Randomized scoreboard bench for awb_gain_stat against a plain-arithmetic gray-world model.
module tb_awb_gain_stat;

   localparam int DW_IN   = 10;
   localparam int DW_GAIN = 10;
   localparam int DW_DEC  = 8;
   localparam int DW_SUM  = 32;
   localparam int UNITY   = 1 << DW_DEC;
   localparam int GMAX    = (1 << DW_GAIN) - 1;
   localparam int LAT     = 2 * DW_GAIN + 3;

   localparam int M_NORMAL  = 0;
   localparam int M_DROP    = 1;
   localparam int M_DISTURB = 2;
   localparam int M_RST     = 3;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [1:0]           CFA = 2'b00;
   logic                 stat_en = 1'b0;
   logic                 vsync_in = 1'b0;
   logic                 hsync_in = 1'b0;
   logic [DW_IN*4-1:0]   data_in = '0;
   logic [DW_GAIN-1:0]   R_gain, G_gain, B_gain;
   logic                 gain_valid, busy;

   typedef struct {
      int r;
      int g;
      int b;
      int cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   int   last_r = UNITY, last_g = UNITY, last_b = UNITY;

   // Quad position (0=p11 .. 3=p22) of the R and B sample for each CFA code.
   int r_idx[4] = '{1, 0, 3, 2};
   int b_idx[4] = '{2, 3, 0, 1};

   awb_gain_stat #(
      .DW_IN   (DW_IN),
      .DW_GAIN (DW_GAIN),
      .DW_DEC  (DW_DEC),
      .DW_SUM  (DW_SUM)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .CFA        (CFA),
      .stat_en    (stat_en),
      .vsync_in   (vsync_in),
      .hsync_in   (hsync_in),
      .data_in    (data_in),
      .R_gain     (R_gain),
      .G_gain     (G_gain),
      .B_gain     (B_gain),
      .gain_valid (gain_valid),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   function automatic int model_gain(input longint g_sum, input longint d);
      longint n;
      n = (g_sum / 2) * UNITY;
      if (d == 0) return UNITY;
      if (n >= d * (longint'(1) << DW_GAIN)) return GMAX;
      return int'(n / d);
   endfunction

   // Monitor: every gain_valid pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (gain_valid) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_gain_valid at cycle %0d: got pulse, expected none", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("R_gain", R_gain, e.r);
            chk("G_gain", G_gain, e.g);
            chk("B_gain", B_gain, e.b);
            chk("valid_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic frame(input int cfa, input int nq, input bit rnd,
                        input int rv, input int gv, input int bv, input int mode);
      longint rs, gs, bs;
      logic [DW_IN-1:0] p[4];
      logic [63:0] junk;
      int c, er, eb;
      rs = 0; gs = 0; bs = 0;
      @(negedge clk);
      CFA = 2'(cfa);
      stat_en = 1'b1;
      for (int q = 0; q < nq; q++) begin
         for (int k = 0; k < 4; k++) begin
            if (rnd)                 p[k] = DW_IN'($urandom_range(0, (1 << DW_IN) - 1));
            else if (k == r_idx[cfa]) p[k] = DW_IN'(rv);
            else if (k == b_idx[cfa]) p[k] = DW_IN'(bv);
            else                     p[k] = DW_IN'(gv);
            if (k == r_idx[cfa])      rs += p[k];
            else if (k == b_idx[cfa]) bs += p[k];
            else                      gs += p[k];
         end
         data_in  = {p[0], p[1], p[2], p[3]};
         vsync_in = 1'b1;
         hsync_in = 1'b1;
         @(negedge clk);
         if (mode == M_DROP && q == nq / 2) begin
            hsync_in = 1'b0;
            stat_en  = 1'b0;
            @(negedge clk);
            stat_en = 1'b1;
         end else if (rnd && $urandom_range(0, 1) == 1) begin
            junk     = {$urandom(), $urandom()};
            data_in  = junk[DW_IN*4-1:0];
            hsync_in = 1'b0;
            @(negedge clk);
         end
      end
      c = cyc;
      vsync_in = 1'b0;
      hsync_in = 1'b0;
      if (mode != M_DROP) begin
         er = model_gain(gs, rs);
         eb = model_gain(gs, bs);
         sb.push_back('{r: er, g: UNITY, b: eb, cyc: c + 1 + LAT});
         last_r = er; last_g = UNITY; last_b = eb;
      end
      repeat (5) @(negedge clk);
      chk("busy_during_div", busy, (mode == M_DROP) ? 0 : 1);
      if (mode == M_DISTURB) begin
         junk     = {$urandom(), $urandom()};
         data_in  = junk[DW_IN*4-1:0];
         vsync_in = 1'b1;
         hsync_in = 1'b1;
         stat_en  = 1'b0;
         repeat (3) @(negedge clk);
         vsync_in = 1'b0;
         hsync_in = 1'b0;
         stat_en  = 1'b1;
      end
      if (mode == M_RST) begin
         while (cyc < c + 15) @(negedge clk);
         chk("busy_before_reset", busy, 1);
         rst_n = 1'b0;
         #1;
         chk("rst_R_gain", R_gain, UNITY);
         chk("rst_G_gain", G_gain, UNITY);
         chk("rst_B_gain", B_gain, UNITY);
         chk("rst_busy", busy, 0);
         chk("rst_gain_valid", gain_valid, 0);
         void'(sb.pop_back());
         last_r = UNITY; last_g = UNITY; last_b = UNITY;
         repeat (2) @(negedge clk);
         rst_n = 1'b1;
      end
      while (cyc < c + 28) @(negedge clk);
      chk("busy_after_div", busy, 0);
      if (mode == M_DROP) begin
         chk("drop_R_gain_held", R_gain, last_r);
         chk("drop_G_gain_held", G_gain, last_g);
         chk("drop_B_gain_held", B_gain, last_b);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_R_gain", R_gain, UNITY);
      chk("reset_G_gain", G_gain, UNITY);
      chk("reset_B_gain", B_gain, UNITY);
      chk("reset_gain_valid", gain_valid, 0);
      chk("reset_busy", busy, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      frame(1, 4, 1'b0, 100, 200, 400, M_NORMAL);
      for (int c = 0; c < 4; c++) frame(c, 3, 1'b0, 300, 300, 300, M_NORMAL);
      frame(2, 5, 1'b0, 0, 500, 500, M_NORMAL);
      frame(3, 1, 1'b0, 1, 1023, 1023, M_NORMAL);
      frame(0, 4, 1'b1, 0, 0, 0, M_DROP);
      frame(1, 4, 1'b1, 0, 0, 0, M_NORMAL);
      frame(2, 4, 1'b1, 0, 0, 0, M_RST);
      frame(3, 3, 1'b0, 100, 200, 400, M_NORMAL);
      frame(0, 5, 1'b1, 0, 0, 0, M_DISTURB);
      for (int i = 0; i < 6; i++)
         frame(int'($urandom_range(0, 3)), int'($urandom_range(1, 8)), 1'b1, 0, 0, 0, M_NORMAL);

      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
